// File: rtl/dds_mode_pkg.sv
// Shared definitions for the DDS output-mode path: mode codes, sequencer states and gain scale.
package dds_mode_pkg;

    localparam logic [2:0] MODE_SIN   = 3'd0;
    localparam logic [2:0] MODE_AM    = 3'd1;
    localparam logic [2:0] MODE_FM    = 3'd2;
    localparam logic [2:0] MODE_AM_DE = 3'd3;
    localparam logic [2:0] MODE_FM_DE = 3'd4;
    localparam logic [2:0] MODE_MAX   = 3'd4;

    localparam logic [8:0] GAIN_UNITY = 9'd256;

    typedef enum logic [2:0] {
        IDLE,
        FADE_OUT,
        SWITCH,
        SETTLE,
        FADE_IN
    } state_t;

    function automatic logic mode_valid(input logic [2:0] m);
        return m <= MODE_MAX;
    endfunction

endpackage

// File: rtl/mode_switch_ctrl_if.sv
// Mode-change request handshake between the command decoder and the mode sequencer.
interface mode_switch_ctrl_if;
    logic       req_valid;
    logic [2:0] req_mode;
    logic       req_ready;
    logic       req_err;

    modport master (output req_valid, req_mode, input req_ready, req_err);
    modport slave  (input req_valid, req_mode, output req_ready, req_err);
endinterface

// File: rtl/gain_scaler.sv
// Registered envelope multiply: sig_out = (sig_in * gain) >>> 8, floor truncation.
module gain_scaler (
    input  logic               clk_100M,
    input  logic               rst,
    input  logic signed [15:0] sig_in,
    input  logic        [8:0]  gain,
    output logic signed [15:0] sig_out
);

    logic signed [25:0] prod;

    // gain is zero-extended so it multiplies as a non-negative value
    assign prod = sig_in * $signed({1'b0, gain});

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            sig_out <= '0;
        end else begin
            sig_out <= 16'(prod >>> 8);
        end
    end

endmodule

// File: rtl/mode_switch_ctrl.sv
// Click-free DDS output-mode sequencer: fade out, switch mode, settle, fade back in.
//
//   state    | meaning
//   IDLE     | gain at unity, accepting mode-change requests
//   FADE_OUT | gain ramps down one step per tick wrap until 0
//   SWITCH   | one cycle at zero gain; mode_sel takes the pending mode
//   SETTLE   | zero gain held SETTLE_CYC cycles while the new path settles
//   FADE_IN  | gain ramps up one step per tick wrap until unity
module mode_switch_ctrl
    import dds_mode_pkg::*;
#(
    parameter int TICK_DIV   = 100,
    parameter int RAMP_STEP  = 1,
    parameter int SETTLE_CYC = 1000
) (
    input  logic               clk_100M,
    input  logic               rst,
    mode_switch_ctrl_if.slave  req,
    input  logic signed [15:0] sig_in,
    output logic signed [15:0] sig_out,
    output logic        [2:0]  mode_sel,
    output logic               busy,
    output logic        [8:0]  gain
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);
    localparam logic [9:0]    STEP        = 10'(RAMP_STEP);

    state_t        state, state_next;
    logic [TW-1:0] tick, tick_d;
    logic [SW-1:0] settle_cnt, settle_d;
    logic [8:0]    gain_d;
    logic [2:0]    mode_d, pending, pending_d;
    logic          err_d, err_q, ready_q;
    logic          accept, tick_wrap;
    logic [9:0]    gain_up_w;
    logic [8:0]    gain_up, gain_dn;

    assign accept    = req.req_valid && ready_q;
    assign tick_wrap = (tick == TICK_LAST);
    assign gain_up_w = {1'b0, gain} + STEP;
    assign gain_up   = (gain_up_w >= 10'(GAIN_UNITY)) ? GAIN_UNITY : gain_up_w[8:0];
    assign gain_dn   = ({1'b0, gain} > STEP) ? (gain - STEP[8:0]) : 9'd0;

    assign req.req_ready = ready_q;
    assign req.req_err   = err_q;

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state      <= IDLE;
            tick       <= '0;
            settle_cnt <= '0;
            gain       <= GAIN_UNITY;
            mode_sel   <= MODE_SIN;
            pending    <= MODE_SIN;
            err_q      <= 1'b0;
            busy       <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state      <= state_next;
            tick       <= tick_d;
            settle_cnt <= settle_d;
            gain       <= gain_d;
            mode_sel   <= mode_d;
            pending    <= pending_d;
            err_q      <= err_d;
            // registered from the next state so busy/ready never overlap
            busy       <= (state_next != IDLE);
            ready_q    <= (state_next == IDLE);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (accept && mode_valid(req.req_mode) && (req.req_mode != mode_sel))
                          state_next = FADE_OUT;
            FADE_OUT: if (tick_wrap && (gain_dn == 9'd0)) state_next = SWITCH;
            SWITCH:   state_next = SETTLE;
            SETTLE:   if (settle_cnt == '0) state_next = FADE_IN;
            FADE_IN:  if (tick_wrap && (gain_up == GAIN_UNITY)) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        tick_d    = tick_wrap ? '0 : tick + 1'b1;
        settle_d  = settle_cnt;
        gain_d    = gain;
        mode_d    = mode_sel;
        pending_d = pending;
        err_d     = 1'b0;
        case (state)
            IDLE: begin
                tick_d = '0;
                if (accept) begin
                    if (!mode_valid(req.req_mode)) err_d = 1'b1;
                    else                           pending_d = req.req_mode;
                end
            end
            FADE_OUT: if (tick_wrap) gain_d = gain_dn;
            SWITCH: begin
                tick_d   = '0;
                mode_d   = pending;
                settle_d = SETTLE_LOAD;
            end
            SETTLE: begin
                tick_d = '0;
                if (settle_cnt != '0) settle_d = settle_cnt - 1'b1;
            end
            FADE_IN: if (tick_wrap) gain_d = gain_up;
            default: tick_d = '0;
        endcase
    end

    gain_scaler u_gain_scaler (
        .clk_100M (clk_100M),
        .rst      (rst),
        .sig_in   (sig_in),
        .gain     (gain),
        .sig_out  (sig_out)
    );

endmodule

// File: tb/tb_mode_switch_ctrl.sv
// Directed bench for mode_switch_ctrl with TICK_DIV=2, RAMP_STEP=64, SETTLE_CYC=4.
module tb_mode_switch_ctrl;

    logic               clk_100M = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] sig_in;
    logic signed [15:0] sig_out;
    logic        [2:0]  mode_sel;
    logic               busy;
    logic        [8:0]  gain;

    int n_checks = 0;
    int n_errors = 0;

    // gain after each edge E0+i of a full sequence, i = 0..21
    logic [8:0] exp_gain [0:21] = '{9'd256, 9'd256, 9'd192, 9'd192, 9'd128, 9'd128, 9'd64, 9'd64,
                                    9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0,
                                    9'd64, 9'd64, 9'd128, 9'd128, 9'd192, 9'd192, 9'd256};

    mode_switch_ctrl_if req_if ();

    mode_switch_ctrl #(
        .TICK_DIV   (2),
        .RAMP_STEP  (64),
        .SETTLE_CYC (4)
    ) dut (
        .clk_100M (clk_100M),
        .rst      (rst),
        .req      (req_if.slave),
        .sig_in   (sig_in),
        .sig_out  (sig_out),
        .mode_sel (mode_sel),
        .busy     (busy),
        .gain     (gain)
    );

    always #5 clk_100M = ~clk_100M;

    task automatic step();
        @(posedge clk_100M);
        #1;
    endtask

    task automatic test_reset();
        req_if.req_valid = 1'b1;
        req_if.req_mode  = 3'd1;
        step();
        req_if.req_valid = 1'b0;
        repeat (16) step();
        n_checks++;
        if (gain !== 9'd64 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_reset: gain=%0d busy=%0b, required gain=64 busy=1", gain, busy);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (mode_sel !== 3'd0 || gain !== 9'd256) begin
            n_errors++;
            $display("FAIL reset_mode_gain: mode_sel=%0d gain=%0d, required 0 and 256", mode_sel, gain);
        end
        n_checks++;
        if (busy !== 1'b0 || req_if.req_ready !== 1'b1 || req_if.req_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: busy=%0b ready=%0b err=%0b, required 0 1 0",
                     busy, req_if.req_ready, req_if.req_err);
        end
        n_checks++;
        if (sig_out !== 16'sh0000) begin
            n_errors++;
            $display("FAIL reset_sig_out: got %h, required 0000", sig_out);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (sig_out !== 16'sh4000 || gain !== 9'd256) begin
            n_errors++;
            $display("FAIL post_reset: sig_out=%h gain=%0d, required 4000 and 256", sig_out, gain);
        end
    endtask

    task automatic test_switch();
        logic [8:0]  prev_g;
        logic [15:0] exp_sig;
        req_if.req_valid = 1'b1;
        req_if.req_mode  = 3'd2;
        for (int i = 0; i <= 21; i++) begin
            step();
            if (i == 0) req_if.req_valid = 1'b0;
            prev_g  = (i == 0) ? 9'd256 : exp_gain[i-1];
            exp_sig = 16'(prev_g * 64);
            n_checks++;
            if (gain !== exp_gain[i]) begin
                n_errors++;
                $display("FAIL switch_gain[%0d]: got %0d, required %0d", i, gain, exp_gain[i]);
            end
            n_checks++;
            if (mode_sel !== ((i >= 9) ? 3'd2 : 3'd0)) begin
                n_errors++;
                $display("FAIL switch_mode[%0d]: got %0d, required %0d", i, mode_sel, (i >= 9) ? 2 : 0);
            end
            n_checks++;
            if (busy !== (i < 21) || req_if.req_ready !== (i == 21)) begin
                n_errors++;
                $display("FAIL switch_handshake[%0d]: busy=%0b ready=%0b", i, busy, req_if.req_ready);
            end
            n_checks++;
            if (sig_out !== exp_sig) begin
                n_errors++;
                $display("FAIL switch_sig_out[%0d]: got %h, required %h", i, sig_out, exp_sig);
            end
        end
    endtask

    task automatic test_invalid();
        logic [2:0] bad [0:1] = '{3'd5, 3'd7};
        for (int k = 0; k < 2; k++) begin
            req_if.req_valid = 1'b1;
            req_if.req_mode  = bad[k];
            step();
            req_if.req_valid = 1'b0;
            n_checks++;
            if (req_if.req_err !== 1'b1) begin
                n_errors++;
                $display("FAIL invalid_err_pulse(mode %0d): got %0b, required 1", bad[k], req_if.req_err);
            end
            n_checks++;
            if (mode_sel !== 3'd2 || gain !== 9'd256 || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL invalid_state: mode_sel=%0d gain=%0d busy=%0b, required 2 256 0",
                         mode_sel, gain, busy);
            end
            step();
            n_checks++;
            if (req_if.req_err !== 1'b0 || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL invalid_err_clear: err=%0b busy=%0b, required 0 0", req_if.req_err, busy);
            end
        end
    endtask

    task automatic test_same_mode();
        req_if.req_valid = 1'b1;
        req_if.req_mode  = 3'd2;
        step();
        req_if.req_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || req_if.req_ready !== 1'b1 || gain !== 9'd256 || req_if.req_err !== 1'b0) begin
            n_errors++;
            $display("FAIL same_mode: busy=%0b ready=%0b gain=%0d err=%0b, required 0 1 256 0",
                     busy, req_if.req_ready, gain, req_if.req_err);
        end
        step();
        n_checks++;
        if (busy !== 1'b0 || mode_sel !== 3'd2) begin
            n_errors++;
            $display("FAIL same_mode_hold: busy=%0b mode_sel=%0d, required 0 2", busy, mode_sel);
        end
    endtask

    task automatic test_back_to_back();
        req_if.req_valid = 1'b1;
        req_if.req_mode  = 3'd4;
        step();
        req_if.req_mode  = 3'd3;
        for (int i = 1; i <= 21; i++) begin
            step();
            n_checks++;
            if (req_if.req_ready !== (i == 21)) begin
                n_errors++;
                $display("FAIL b2b_ready[%0d]: got %0b, required %0b", i, req_if.req_ready, i == 21);
            end
        end
        n_checks++;
        if (mode_sel !== 3'd4 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_first_end: mode_sel=%0d busy=%0b, required 4 0", mode_sel, busy);
        end
        step();
        req_if.req_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || req_if.req_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_second_accept: busy=%0b ready=%0b, required 1 0", busy, req_if.req_ready);
        end
        repeat (20) step();
        n_checks++;
        if (req_if.req_ready !== 1'b0 || mode_sel !== 3'd3) begin
            n_errors++;
            $display("FAIL b2b_second_late: ready=%0b mode_sel=%0d, required 0 3", req_if.req_ready, mode_sel);
        end
        step();
        n_checks++;
        if (req_if.req_ready !== 1'b1 || gain !== 9'd256 || mode_sel !== 3'd3) begin
            n_errors++;
            $display("FAIL b2b_second_end: ready=%0b gain=%0d mode_sel=%0d, required 1 256 3",
                     req_if.req_ready, gain, mode_sel);
        end
    endtask

    task automatic test_scaling();
        int budget;
        sig_in = -16'sd1;
        req_if.req_valid = 1'b1;
        req_if.req_mode  = 3'd0;
        step();
        req_if.req_valid = 1'b0;
        repeat (7) step();
        n_checks++;
        if (gain !== 9'd64 || sig_out !== -16'sd1) begin
            n_errors++;
            $display("FAIL scale_neg_gain64: gain=%0d sig_out=%0d, required 64 and -1", gain, sig_out);
        end
        budget = 40;
        while (req_if.req_ready !== 1'b1 && budget > 0) begin
            step();
            budget--;
        end
        n_checks++;
        if (budget == 0) begin
            n_errors++;
            $display("FAIL scale_wait_idle: req_ready=%0b after 40 cycles, required 1", req_if.req_ready);
        end
        sig_in = 16'sh8000;
        step();
        n_checks++;
        if (sig_out !== 16'sh8000) begin
            n_errors++;
            $display("FAIL scale_min_unity: got %h, required 8000", sig_out);
        end
        sig_in = 16'sh7fff;
        step();
        n_checks++;
        if (sig_out !== 16'sh7fff || mode_sel !== 3'd0) begin
            n_errors++;
            $display("FAIL scale_max_unity: sig_out=%h mode_sel=%0d, required 7fff 0", sig_out, mode_sel);
        end
    endtask

    initial begin
        sig_in           = 16'sh4000;
        req_if.req_valid = 1'b0;
        req_if.req_mode  = 3'd0;
        repeat (3) step();
        rst = 1'b0;
        test_reset();
        test_switch();
        test_invalid();
        test_same_mode();
        test_back_to_back();
        test_scaling();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mode_switch_ctrl.md
# mode_switch_ctrl

Sequencer that owns the DDS output-mode select and makes every mode change click-free. It accepts mode-change requests over a valid/ready handshake and drives the output multiplexer's 3-bit mode code. It applies a gain envelope to the multiplexed sample stream: fade to zero, switch mode, wait for the new path (notably demodulator filters) to settle, then fade back to unity. It sits between the front-panel/command decoder and the DAC-bound sample path, directly after the output mode multiplexer.

## Interface
- TICK_DIV, 100: clk_100M cycles per gain step; 100 gives 1 µs per step.
- RAMP_STEP, 1: gain change per step, range 1..256.
- SETTLE_CYC, 1000: cycles held at zero gain after the mode switch; must be ≥1.

- clk_100M  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  mode-change request present
- req_mode  in  3  requested mode: 0 sine, 1 AM, 2 FM, 3 AM-demod, 4 FM-demod
- req_ready  out  1  high only in IDLE; a request is accepted on a clk_100M edge with req_valid && req_ready
- req_err  out  1  one-cycle pulse when an accepted req_mode is greater than 4
- mode_sel  out  3  mode code driven to the output multiplexer
- busy  out  1  high in every state except IDLE
- sig_in  in  16  signed sample from the multiplexer
- sig_out  out  16  signed, gain-scaled sample
- gain  out  9  current envelope gain, 0..256; 256 is unity

## Operation
- Reset values: state IDLE, mode_sel 0, gain 256, sig_out 0, req_err 0, busy 0, tick counter 0. A reset mid-sequence aborts the sequence immediately with these values. There is no fade on reset.
- IDLE: handling of an accepted request:
  - req_mode > 4: req_err pulses on the next cycle and nothing else changes.
  - req_mode == mode_sel: no-op, stay in IDLE, no error.
  - Otherwise: latch req_mode as pending and go to FADE_OUT.
- FADE_OUT: the tick counter counts 0..TICK_DIV-1. On each wrap, gain decrements by RAMP_STEP, saturating at 0. On the edge where gain becomes 0, go to SWITCH.
- SWITCH: one cycle. mode_sel takes the pending value; go to SETTLE.
- SETTLE: gain is held at 0 for SETTLE_CYC cycles, then go to FADE_IN.
- FADE_IN: gain increments by RAMP_STEP on each tick wrap, saturating at 256. On the edge where gain becomes 256, go to IDLE.
- The tick counter clears on entry to FADE_OUT and FADE_IN.
- req_valid is ignored while busy. A requester holds req_valid until it sees req_ready.
- Datapath: sig_out = (sig_in × gain) >>> 8.
  - Signed 16 × unsigned 9 product, 25-bit; take bits [23:8].
  - Arithmetic truncation toward −∞, no rounding.
  - At gain 256, sig_out equals sig_in exactly. At gain 0, sig_out is 0.
  - No overflow is possible, because gain ≤ 256.

## Timing
- sig_in to sig_out: 1 cycle latency, using the gain value registered in the same cycle as sig_in.
- Let N = ceil(256 / RAMP_STEP) and E0 = the acceptance edge:
  - gain steps down at E0+T, E0+2T, … and reaches 0 (state SWITCH) at E0+N·T.
  - mode_sel changes at E0+N·T+1.
  - FADE_IN is entered at E0+N·T+1+SETTLE_CYC.
  - gain reaches 256, and req_ready rises, at E0+2·N·T+1+SETTLE_CYC.
- mode_sel never changes while gain ≠ 0.
- busy and req_ready are registered and always mutually exclusive.
- A request presented on the same edge that IDLE is re-entered is not accepted. It is accepted on the following edge.

## Structure
- Shared package dds_mode_pkg holds:
  - mode code constants: MODE_SIN=0, MODE_AM=1, MODE_FM=2, MODE_AM_DE=3, MODE_FM_DE=4, MODE_MAX=4;
  - the state enum {IDLE, FADE_OUT, SWITCH, SETTLE, FADE_IN};
  - GAIN_UNITY=256.
- The output multiplexer imports the same mode constants.
- One sub-module: gain_scaler, the registered signed × unsigned multiply and shift, with synchronous active-high reset. The FSM, tick counter and settle counter stay in mode_switch_ctrl.

## Test plan
All scenarios use TICK_DIV=2, RAMP_STEP=64, SETTLE_CYC=4, sig_in held at 16'sh4000 unless stated.
- Reset: assert rst mid-FADE_IN -> next cycle mode_sel=0, gain=256, busy=0, req_ready=1, sig_out=0.
- Switch 0→2: accept req_mode=2 -> gain follows 256,192,128,64,0, each value held 2 cycles. mode_sel becomes 2 exactly one cycle after gain reaches 0. req_ready rises 21 cycles after acceptance. sig_out passes through 0x3000, 0x2000, 0x1000, 0.
- Invalid: req_mode=5 in IDLE -> req_err pulses for one cycle; mode_sel, gain and busy are unchanged.
- Same mode: req_mode equal to mode_sel -> accepted, busy stays 0, gain stays 256.
- Back-pressure: hold req_valid with req_mode=3 throughout a busy sequence -> req_ready stays low until the sequence ends; the request is accepted on the first IDLE edge and a second sequence runs to mode 3.
- Scaling: gain 64 with sig_in=−1 -> sig_out=−1; sig_in=16'sh8000 at gain 256 -> sig_out=16'sh8000 after 1 cycle.
